tuser_out_fsm: RTL
==================

TUSER_OUT_FSM -- requirements
Module: tuser_out_fsm

Interface
REQ-001 SHALL have parameter TUPLE_DEPTH, default 4: depth of the tuple FIFO, power of two, range 2..16.
REQ-002 SHALL have port tout_aclk  input  1: single clock for all logic.
REQ-003 SHALL have port tout_arst  input  1: reset, asynchronous, active-high.
REQ-004 SHALL have port tout_valid  input  1: output-tuple strobe from the SDNet engine, one pulse per packet.
REQ-005 SHALL have port tout_data  input  128: output tuple, valid when tout_valid=1.
REQ-006 SHALL have port tout_s_avalid  input  1: packet-stream beat valid from the engine.
REQ-007 SHALL have port tout_s_adata  input  256: packet-stream beat data.
REQ-008 SHALL have port tout_s_akeep  input  32: packet-stream byte enables.
REQ-009 SHALL have port tout_s_alast  input  1: last beat of the packet.
REQ-010 SHALL have port tout_s_aready  output  1: beat accepted when tout_s_avalid=1 and tout_s_aready=1.
REQ-011 SHALL have ports tout_m_avalid, tout_m_adata, tout_m_akeep, tout_m_alast  output  1/256/32/1: AXIS master toward the output port.
REQ-012 SHALL have port tout_m_atuser  output  128: metadata, carrying the tuple on the first beat only.
REQ-013 SHALL have port tout_m_aready  input  1: downstream ready.
REQ-014 SHALL have port tout_drop_cnt  output  16: count of tuples dropped on FIFO overflow.

Function
REQ-015 SHALL push tout_data into the tuple FIFO on every cycle with tout_valid=1 when count<TUPLE_DEPTH, or when count=TUPLE_DEPTH and a pop happens in the same cycle.
REQ-016 SHALL discard a tuple presented while the FIFO is full with no same-cycle pop, and SHALL increment tout_drop_cnt, saturating at 0xFFFF.
REQ-017 SHALL implement a two-state FSM: SOP (awaiting first beat) and BODY (mid-packet).
REQ-018 SHALL define out_free = !tout_m_avalid || tout_m_aready.
REQ-019 SHALL drive tout_s_aready = out_free && (state==BODY || FIFO non-empty).
REQ-020 SHALL load the output register with adata, akeep and alast on every accepted beat, set tout_m_avalid=1, and give a latency of exactly 1 cycle from input to output.
REQ-021 On an accepted beat in SOP, SHALL load tout_m_atuser with the FIFO head and pop the FIFO in the same cycle.
REQ-022 On an accepted beat in BODY, SHALL load tout_m_atuser with 0.
REQ-023 SHALL make these FSM transitions on an accepted beat: SOP with alast=0 -> BODY; SOP with alast=1 -> SOP (single-beat packet); BODY with alast=1 -> SOP; BODY with alast=0 -> BODY.
REQ-024 SHALL clear tout_m_avalid when tout_m_aready=1 and no new beat is accepted that cycle.
REQ-025 SHALL hold all output register contents stable while tout_m_avalid=1 and tout_m_aready=0.
REQ-026 SHALL stall the stream in SOP with the FIFO empty (tout_s_aready=0) until a tuple is present; a tuple arriving in cycle N SHALL allow acceptance in cycle N+1 at earliest.
REQ-027 SHALL sustain one beat per cycle under continuous tout_m_aready=1, including back-to-back packets, while tuples are available.
REQ-028 SHALL permit a FIFO push and pop in the same cycle, leaving the count unchanged.
REQ-029 SHALL wrap the FIFO pointers modulo TUPLE_DEPTH and keep tuple order strictly FIFO.

Reset
REQ-030 While tout_arst=1, SHALL hold tout_m_avalid=0, tout_m_adata=0, tout_m_akeep=0, tout_m_alast=0, tout_m_atuser=0, tout_s_aready=0, tout_drop_cnt=0, FIFO empty and state=SOP.
REQ-031 SHALL abandon any packet in flight on reset mid-packet; the first beat accepted after reset SHALL be treated as SOP.
REQ-032 SHALL accept beats from the first tout_aclk rising edge after tout_arst deasserts.

Verification
REQ-033 SHALL pass: tuple 0xA5..A5, then a 3-beat packet with m_aready=1 -> 3 output beats, atuser=0xA5..A5 on beat 1, 0 on beats 2-3, alast on beat 3, each beat 1 cycle after input.
REQ-034 SHALL pass: packet presented with no tuple for 5 cycles, then tuple T -> s_aready=0 for those 5 cycles, first beat accepted the cycle after T with atuser=T.
REQ-035 SHALL pass: 6 tuples back-to-back into an empty FIFO with no stream traffic (depth 4) -> 4 stored, tout_drop_cnt=2, the next 4 packets carry tuples 1-4 in order.
REQ-036 SHALL pass: m_aready toggling 1/0 every cycle during a 4-beat packet -> no beat lost or duplicated, outputs stable while stalled.
REQ-037 SHALL pass: single-beat packets back-to-back with tuples T1, T2, T3 preloaded -> 3 consecutive output beats, each alast=1, atuser=T1, T2, T3.
REQ-038 SHALL pass: tout_arst asserted on beat 2 of a 4-beat packet -> outputs zero immediately; the next packet after release takes a fresh tuple on its first beat.

Source files
------------

// File: rtl/tuser_out_fsm.sv
// tuser_out_fsm: joins the SDNet output-tuple strobe with the engine's packet
// stream. Each tuple is queued in a small FIFO and attached as tout_m_atuser
// to the first beat of the next packet. Later beats carry zero metadata.
// The output stage is a single register slice with one cycle of latency.
module tuser_out_fsm #(
    parameter int TUPLE_DEPTH = 4
) (
    input  logic         tout_aclk,
    input  logic         tout_arst,

    input  logic         tout_valid,
    input  logic [127:0] tout_data,

    input  logic         tout_s_avalid,
    input  logic [255:0] tout_s_adata,
    input  logic [31:0]  tout_s_akeep,
    input  logic         tout_s_alast,
    output logic         tout_s_aready,

    output logic         tout_m_avalid,
    output logic [255:0] tout_m_adata,
    output logic [31:0]  tout_m_akeep,
    output logic         tout_m_alast,
    output logic [127:0] tout_m_atuser,
    input  logic         tout_m_aready,

    output logic [15:0]  tout_drop_cnt
);

    localparam int PTR_W = $clog2(TUPLE_DEPTH);
    localparam int CNT_W = $clog2(TUPLE_DEPTH) + 1;

    // Elaboration-time guard on the FIFO depth: power of two in 2..16.
    if (TUPLE_DEPTH < 2 || TUPLE_DEPTH > 16 ||
        (TUPLE_DEPTH & (TUPLE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("tuser_out_fsm: TUPLE_DEPTH must be a power of two in 2..16");
    end

    typedef enum logic {
        SOP  = 1'b0,
        BODY = 1'b1
    } state_t;

    state_t state;

    // Tuple FIFO storage and bookkeeping
    logic [127:0]     fifo_mem [TUPLE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [127:0]     fifo_head;

    logic fifo_empty;
    logic fifo_full;
    logic out_free;
    logic beat_acc;
    logic push;
    logic pop;
    logic drop;

    assign fifo_head  = fifo_mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(TUPLE_DEPTH));

    // Handshake decode: a full FIFO still takes a tuple when the head leaves
    // in the same cycle, so pop feeds into the push decision.
    always_comb begin
        out_free      = !tout_m_avalid || tout_m_aready;
        tout_s_aready = out_free && ((state == BODY) || !fifo_empty);
        beat_acc      = tout_s_avalid && tout_s_aready;
        pop           = beat_acc && (state == SOP);
        push          = tout_valid && (!fifo_full || pop);
        drop          = tout_valid && !push;
    end

    // Tuple storage write port; contents need no reset since count gates reads.
    always_ff @(posedge tout_aclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= tout_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge tout_aclk or posedge tout_arst) begin
        if (tout_arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Saturating count of tuples lost to overflow.
    always_ff @(posedge tout_aclk or posedge tout_arst) begin
        if (tout_arst) begin
            tout_drop_cnt <= '0;
        end else if (drop && (tout_drop_cnt != '1)) begin
            tout_drop_cnt <= tout_drop_cnt + 16'd1;
        end
    end

    // Packet FSM with the registered AXIS output slice.
    always_ff @(posedge tout_aclk or posedge tout_arst) begin
        if (tout_arst) begin
            state         <= SOP;
            tout_m_avalid <= 1'b0;
            tout_m_adata  <= '0;
            tout_m_akeep  <= '0;
            tout_m_alast  <= 1'b0;
            tout_m_atuser <= '0;
        end else if (beat_acc) begin
            tout_m_avalid <= 1'b1;
            tout_m_adata  <= tout_s_adata;
            tout_m_akeep  <= tout_s_akeep;
            tout_m_alast  <= tout_s_alast;
            case (state)
                SOP: begin
                    tout_m_atuser <= fifo_head;
                    if (!tout_s_alast) begin
                        state <= BODY;
                    end
                end
                BODY: begin
                    tout_m_atuser <= '0;
                    if (tout_s_alast) begin
                        state <= SOP;
                    end
                end
                default: begin
                    tout_m_atuser <= '0;
                    state         <= SOP;
                end
            endcase
        end else if (tout_m_aready) begin
            tout_m_avalid <= 1'b0;
        end
    end

endmodule
